// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

  // MIPS immediate word offset -> sign-extended byte displacement
  function automatic logic [31:0] branch_disp(input logic [15:0] off);
    return {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_adder.sv
// Plain modulo-2^W adder shared by the PC+4 and branch-target paths.
module fetch_pc_unit_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: PC register, next-PC select and imem handshake.
//
// state   | meaning
// S_BOOT  | one idle cycle after reset release
// S_FETCH | imem_req high at pc, waiting for imem_ready
// S_ISSUE | inst valid to decode; advance pc when not stalled
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_addr,
  input  logic        err_clr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        addr_err
);

  state_t      state, state_next;
  logic [31:0] branch_target;
  logic [31:0] next_pc;
  logic        issue_go;
  logic        jr_fault;

  fetch_pc_unit_adder #(.W(32)) u_add_seq (
    .a   (pc),
    .b   (PC_STEP),
    .sum (pc_plus4)
  );

  fetch_pc_unit_adder #(.W(32)) u_add_br (
    .a   (pc_plus4),
    .b   (branch_disp(branch_offset)),
    .sum (branch_target)
  );

  // Outputs decode straight from state so an async reset drops them at once
  assign imem_req   = (state == S_FETCH);
  assign inst_valid = (state == S_ISSUE);
  assign imem_addr  = pc;
  assign issue_go   = (state == S_ISSUE) && !stall;

  always_comb begin
    state_next = state;
    next_pc    = pc_plus4;
    jr_fault   = 1'b0;

    case (state)
      S_BOOT:  state_next = S_FETCH;
      S_FETCH: if (imem_ready) state_next = S_ISSUE;
      S_ISSUE: if (!stall) state_next = S_FETCH;
      default: state_next = S_BOOT;
    endcase

    if (jump_reg) begin
      if (jr_addr[1:0] == 2'b00) begin
        next_pc = jr_addr;
      end else begin
        next_pc  = EXC_VECTOR;
        jr_fault = issue_go;
      end
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      pc       <= RESET_VECTOR;
      inst     <= 32'd0;
      addr_err <= 1'b0;
    end else begin
      state <= state_next;
      if (issue_go) pc <= next_pc;
      if ((state == S_FETCH) && imem_ready) inst <= imem_rdata;
      // a new fault outranks a concurrent clear
      if (jr_fault)     addr_err <= 1'b1;
      else if (err_clr) addr_err <= 1'b0;
    end
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch front end for the MIPS core.
- Holds the program counter and computes the next PC: sequential, branch, jump or jump-register.
- Runs a request/ready handshake with instruction memory and presents one fetched instruction at a time to decode.
- Sits directly upstream of the PC+4 / branch-target adders and feeds their operands.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- EXC_VECTOR, 32'h8000_0180, PC loaded on a misaligned jump-register target.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  decode not ready; hold the current instruction and PC
- branch_taken  in  1  take the branch in the current issue cycle
- branch_offset  in  16  signed word offset (MIPS immediate)
- jump  in  1  J/JAL in the current issue cycle
- jump_target  in  26  J-type target field
- jump_reg  in  1  JR/JALR in the current issue cycle
- jr_addr  in  32  register-sourced target
- err_clr  in  1  clears addr_err
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (equals pc)
- imem_ready  in  1  imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- inst_valid  out  1  inst is valid for decode
- inst  out  32  registered instruction
- pc  out  32  address of inst / current fetch
- pc_plus4  out  32  pc+4, combinational
- addr_err  out  1  sticky misaligned-JR flag

Behaviour:
- Reset (async, rst_n=0) sets: pc=RESET_VECTOR, state=S_BOOT, imem_req=0, inst_valid=0, inst=0, addr_err=0. pc_plus4 therefore equals RESET_VECTOR+4.
- Reset asserted mid-fetch or mid-issue aborts immediately. Outputs take reset values without waiting for a clock edge.
- FSM state S_BOOT:
  - One cycle after rst_n rises, with all outputs idle.
  - Then moves to S_FETCH.
- FSM state S_FETCH:
  - imem_req=1 and imem_addr=pc.
  - When imem_ready=1: capture imem_rdata into inst and go to S_ISSUE.
  - When imem_ready=0: stay, with no timeout.
- FSM state S_ISSUE:
  - imem_req=0 and inst_valid=1.
  - When stall=1: hold inst and pc, and ignore all redirect inputs.
  - When stall=0: load pc with next_pc and go to S_FETCH.
- Latency:
  - imem_ready high → inst_valid high on the next cycle.
  - Issue accepted → next imem_req on the next cycle.
  - Minimum 2 cycles per instruction.
- next_pc priority, evaluated only in S_ISSUE with stall=0:
  1. jump_reg: next_pc = jr_addr if jr_addr[1:0]==0. Otherwise next_pc = EXC_VECTOR and addr_err is set.
  2. jump: next_pc = {pc_plus4[31:28], jump_target, 2'b00}.
  3. branch_taken: next_pc = pc_plus4 + (sign-extended branch_offset << 2).
  4. Otherwise next_pc = pc_plus4.
- Arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0 with no error. A backward branch below 0 also wraps.
- Lower-priority redirect inputs asserted together with a higher one are ignored.
- addr_err stays set until err_clr=1 is sampled. If set and clear occur in the same cycle, set wins.
- Redirect inputs outside S_ISSUE have no effect.

Decomposition:
- Shared package holds:
  - state encodings S_BOOT/S_FETCH/S_ISSUE (2 bits)
  - PC_STEP=32'd4
  - default RESET_VECTOR/EXC_VECTOR constants
- Instantiate the existing Adder module twice: pc + PC_STEP, and pc_plus4 + shifted offset.
- Next-PC selection and the FSM stay inline; no further sub-module.

Test Plan:
- Reset release, imem_ready=1 every fetch cycle, no redirects → imem_addr sequence 0x0,0x4,0x8; inst_valid every 2nd cycle; inst matches imem_rdata.
- At pc=0x100: branch_taken=1, offset=16'hFFFE → next imem_addr=0x0FC. Then offset=16'h0003 from pc=0x0FC → 0x10C.
- At pc=0x0040_0010: jump=1, target=26'h010_0000 → next pc=0x0040_0000. Same cycle with branch_taken=1 → jump wins.
- jump_reg=1, jr_addr=0x1002 → pc=0x8000_0180 and addr_err=1. Stays 1 until err_clr; err_clr concurrent with a second bad JR → stays 1.
- stall=1 for 3 cycles in S_ISSUE with branch_taken toggling → inst/pc unchanged and imem_req=0. Release with no redirect → pc+4.
- imem_ready held 0 for 5 cycles, then rst_n pulsed low mid-wait → imem_req drops asynchronously; after release, pc=RESET_VECTOR and the fetch restarts after one S_BOOT cycle.
